mc_controller: RTL

//  Multicycle sequencer for the EC413 CPU. Owns the PC, which addresses the instruction memory.

---
 rtl/mc_pkg.sv | 60 ++++++
 rtl/mc_if.sv | 34 +++
 rtl/mc_decode.sv | 81 ++++++++
 rtl/mc_controller.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - shared opcodes, state encoding and decode types for the multicycle sequencer
package mc_pkg;

    localparam logic [5:0] OP_NOP = 6'b000000;
    localparam logic [5:0] OP_J   = 6'b000001;
    localparam logic [5:0] OP_JAL = 6'b000010;
    localparam logic [5:0] OP_BNE = 6'b100001;
    localparam logic [5:0] OP_BLT = 6'b100010;
    localparam logic [5:0] OP_BLE = 6'b100011;
    localparam logic [5:0] OP_LI  = 6'b111001;
    localparam logic [5:0] OP_LUI = 6'b111010;
    localparam logic [5:0] OP_LWI = 6'b111011;
    localparam logic [5:0] OP_SWI = 6'b111100;
    localparam logic [5:0] OP_LW  = 6'b111101;
    localparam logic [5:0] OP_SW  = 6'b111110;

    localparam logic [1:0] WB_ALU  = 2'd0;
    localparam logic [1:0] WB_MEM  = 2'd1;
    localparam logic [1:0] WB_LINK = 2'd2;
    localparam logic [1:0] WB_IMM  = 2'd3;

    localparam logic [2:0] ALU_MOV = 3'b000;
    localparam logic [2:0] ALU_NOT = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b011;
    localparam logic [2:0] ALU_OR  = 3'b100;
    localparam logic [2:0] ALU_AND = 3'b101;
    localparam logic [2:0] ALU_XOR = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4
    } state_e;

    typedef enum logic [3:0] {
        CL_NOP, CL_JMP, CL_JAL, CL_RTYPE, CL_IALU, CL_IMM, CL_BR, CL_LD, CL_ST, CL_ILL
    } op_class_e;

    typedef struct packed {
        op_class_e   cls;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic [4:0]  rd;
        logic [2:0]  alu_op;
        logic        alu_b_imm;
        logic        dmem_abs;
        logic        imm_hi;
        logic [1:0]  wb_sel;
        logic [31:0] imm;
    } dec_t;

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/mc_if.sv
// rtl/mc_if.sv - controller <-> datapath/memory signal bundle
interface mc_if;
    logic [31:0] instr;
    logic        alu_zero;
    logic        alu_neg;
    logic        dmem_ready;
    logic [31:0] pc;
    logic [31:0] ir;
    logic [4:0]  rf_ra;
    logic [4:0]  rf_rb;
    logic        rf_we;
    logic [4:0]  rf_wa;
    logic [1:0]  wb_sel;
    logic        imm_hi;
    logic [2:0]  alu_op;
    logic        alu_b_imm;
    logic        dmem_re;
    logic        dmem_we;
    logic        dmem_abs;
    logic        illegal;
    logic        mem_fault;

    modport master (
        input  instr, alu_zero, alu_neg, dmem_ready,
        output pc, ir, rf_ra, rf_rb, rf_we, rf_wa, wb_sel, imm_hi, alu_op,
               alu_b_imm, dmem_re, dmem_we, dmem_abs, illegal, mem_fault
    );

    modport slave (
        output instr, alu_zero, alu_neg, dmem_ready,
        input  pc, ir, rf_ra, rf_rb, rf_we, rf_wa, wb_sel, imm_hi, alu_op,
               alu_b_imm, dmem_re, dmem_we, dmem_abs, illegal, mem_fault
    );
endinterface

// File: rtl/mc_decode.sv
// rtl/mc_decode.sv - combinational instruction classifier and register/ALU select generation
module mc_decode
    import mc_pkg::*;
(
    input  logic [31:0] ir_i,
    output dec_t        dec_o
);

    logic [5:0] op;
    logic [4:0] fa, fb, fc;

    assign op = ir_i[31:26];
    assign fa = ir_i[25:21];
    assign fb = ir_i[20:16];
    assign fc = ir_i[15:11];

    always_comb begin
        dec_o           = '0;
        dec_o.cls       = CL_ILL;
        dec_o.ra        = fb;
        dec_o.rb        = fc;
        dec_o.rd        = fa;
        dec_o.alu_op    = ALU_MOV;
        dec_o.wb_sel    = WB_ALU;
        dec_o.imm       = sext16(ir_i[15:0]);
        casez (op)
            OP_NOP: dec_o.cls = CL_NOP;
            OP_J:   dec_o.cls = CL_JMP;
            OP_JAL: begin
                dec_o.cls    = CL_JAL;
                dec_o.wb_sel = WB_LINK;
            end
            6'b010???: begin
                dec_o.cls    = CL_RTYPE;
                dec_o.alu_op = op[2:0];
            end
            6'b110???: begin
                dec_o.cls       = CL_IALU;
                dec_o.alu_op    = op[2:0];
                dec_o.alu_b_imm = 1'b1;
            end
            OP_LI, OP_LUI: begin
                dec_o.cls    = CL_IMM;
                dec_o.ra     = fa;
                dec_o.wb_sel = WB_IMM;
                dec_o.imm_hi = (op == OP_LUI);
            end
            OP_BNE, OP_BLT, OP_BLE: begin
                dec_o.cls    = CL_BR;
                dec_o.alu_op = ALU_SUB;
                dec_o.ra     = fa;
                dec_o.rb     = fb;
            end
            OP_LWI: begin
                dec_o.cls      = CL_LD;
                dec_o.dmem_abs = 1'b1;
                dec_o.wb_sel   = WB_MEM;
            end
            OP_LW: begin
                dec_o.cls       = CL_LD;
                dec_o.alu_op    = ALU_ADD;
                dec_o.alu_b_imm = 1'b1;
                dec_o.wb_sel    = WB_MEM;
            end
            // stores carry their data register (field A) on read port B
            OP_SWI: begin
                dec_o.cls      = CL_ST;
                dec_o.dmem_abs = 1'b1;
                dec_o.rb       = fa;
            end
            OP_SW: begin
                dec_o.cls       = CL_ST;
                dec_o.alu_op    = ALU_ADD;
                dec_o.alu_b_imm = 1'b1;
                dec_o.rb        = fa;
            end
            default: dec_o.cls = CL_ILL;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// rtl/mc_controller.sv - multicycle FETCH/DECODE/EXEC/MEM/WB sequencer owning pc, ir and fault flags
module mc_controller
    import mc_pkg::*;
#(
    parameter logic [31:0] PC_RESET    = 32'd0,
    parameter logic [4:0]  LINK_REG    = 5'd31,
    parameter int          MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    mc_if.master bus
);

    // abort fires on the wait cycle that would bring the count up to MEM_TIMEOUT
    localparam logic [3:0] WAIT_LAST = 4'(MEM_TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [3:0]  wait_q, wait_d;
    logic        illegal_q, illegal_d;
    logic        fault_q, fault_d;

    logic        rf_we_c, dmem_re_c, dmem_we_c, br_taken;
    logic [31:0] pc_inc, target;
    dec_t        dec;

    mc_decode u_decode (
        .ir_i  (ir_q),
        .dec_o (dec)
    );

    assign pc_inc = pc_q + 32'd1;
    assign target = pc_inc + dec.imm;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_FETCH;
            pc_q      <= PC_RESET;
            ir_q      <= '0;
            wait_q    <= '0;
            illegal_q <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            wait_q    <= wait_d;
            illegal_q <= illegal_d;
            fault_q   <= fault_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        wait_d    = wait_q;
        illegal_d = illegal_q;
        fault_d   = fault_q;
        rf_we_c   = 1'b0;
        dmem_re_c = 1'b0;
        dmem_we_c = 1'b0;

        case (ir_q[27:26])
            2'b01:   br_taken = ~bus.alu_zero;
            2'b10:   br_taken = bus.alu_neg;
            2'b11:   br_taken = bus.alu_neg | bus.alu_zero;
            default: br_taken = 1'b0;
        endcase

        case (state_q)
            ST_FETCH: begin
                ir_d    = bus.instr;
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                case (dec.cls)
                    CL_NOP, CL_ILL: begin
                        illegal_d = illegal_q | (dec.cls == CL_ILL);
                        pc_d      = pc_inc;
                        state_d   = ST_FETCH;
                    end
                    CL_JMP: begin
                        pc_d    = target;
                        state_d = ST_FETCH;
                    end
                    CL_JAL: begin
                        rf_we_c = 1'b1;
                        pc_d    = target;
                        state_d = ST_FETCH;
                    end
                    default: state_d = ST_EXEC;
                endcase
            end
            ST_EXEC: begin
                case (dec.cls)
                    CL_BR: begin
                        pc_d    = br_taken ? target : pc_inc;
                        state_d = ST_FETCH;
                    end
                    CL_LD, CL_ST: begin
                        wait_d  = '0;
                        state_d = ST_MEM;
                    end
                    default: state_d = ST_WB;
                endcase
            end
            ST_MEM: begin
                dmem_re_c = (dec.cls == CL_LD);
                dmem_we_c = (dec.cls == CL_ST);
                if (bus.dmem_ready) begin
                    if (dec.cls == CL_LD) begin
                        state_d = ST_WB;
                    end else begin
                        pc_d    = pc_inc;
                        state_d = ST_FETCH;
                    end
                end else if (wait_q == WAIT_LAST) begin
                    fault_d = 1'b1;
                    pc_d    = pc_inc;
                    state_d = ST_FETCH;
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end
            ST_WB: begin
                rf_we_c = 1'b1;
                pc_d    = pc_inc;
                state_d = ST_FETCH;
            end
            default: state_d = ST_FETCH;
        endcase
    end

    assign bus.pc        = pc_q;
    assign bus.ir        = ir_q;
    assign bus.rf_ra     = dec.ra;
    assign bus.rf_rb     = dec.rb;
    assign bus.rf_we     = rf_we_c;
    assign bus.rf_wa     = (dec.cls == CL_JAL) ? LINK_REG : dec.rd;
    assign bus.wb_sel    = dec.wb_sel;
    assign bus.imm_hi    = dec.imm_hi;
    assign bus.alu_op    = dec.alu_op;
    assign bus.alu_b_imm = dec.alu_b_imm;
    assign bus.dmem_re   = dmem_re_c;
    assign bus.dmem_we   = dmem_we_c;
    assign bus.dmem_abs  = dec.dmem_abs;
    assign bus.illegal   = illegal_q;
    assign bus.mem_fault = fault_q;

endmodule
